// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Port identifiers used for round-robin history and response routing.
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // Default memory placement.
  localparam logic [31:0] DEF_BASE_ADDR   = 32'h0040_0000;
  localparam int unsigned DEF_DEPTH_WORDS = 64;

endpackage

// File: rtl/mem_addr_check.sv
// Combinational address window / alignment check for the unified memory.
module mem_addr_check
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic [31:0] addr,
  output logic        fault
);

  // One-past-the-end byte address; 33 bits so a window touching 2^32 cannot wrap.
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  // Fault on below-window, at/above-limit, or non word-aligned addresses.
  always_comb begin
    fault = ({1'b0, addr} < {1'b0, BASE_ADDR}) ||
            ({1'b0, addr} >= LIMIT) ||
            (addr[1:0] != 2'b00);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-ported unified memory.
//
// Handshake: a requester raises *_req with stable address (and for the data
// port we/wdata) and holds it until it sees a one-cycle *_ack; rdata/err are
// valid only while ack is high. A request still high in the cycle after its
// ack is a new request. One transaction is in flight at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_dir,
  output logic [31:0] mem_data_input,
  output logic        mem_rd,
  output logic        mem_wd,
  input  logic [31:0] mem_data_output,
  output logic        busy,
  output state_t      fsm_state
);

  state_t      state, state_nxt;
  logic        last_grant;
  logic        grant_d;
  logic        any_req;
  logic [31:0] sel_addr;
  logic        sel_fault;
  logic        lat_port;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        resp_port;
  logic        resp_err;
  logic [31:0] resp_data;

  // Round-robin choice: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    any_req  = if_req || d_req;
    grant_d  = d_req && (!if_req || (last_grant == PORT_IF));
    sel_addr = grant_d ? d_addr : if_addr;
  end

  mem_addr_check #(
    .BASE_ADDR  (BASE_ADDR),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_addr_check (
    .addr (sel_addr),
    .fault(sel_fault)
  );

  // Next-state: faulted grants skip the memory cycle and answer immediately.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (any_req) state_nxt = sel_fault ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register, grant history and the latched transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= PORT_IF;
      lat_port   <= PORT_IF;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && any_req) begin
        last_grant <= grant_d ? PORT_D : PORT_IF;
        lat_port   <= grant_d ? PORT_D : PORT_IF;
        lat_we     <= grant_d && d_we;
        lat_addr   <= sel_addr;
        lat_wdata  <= grant_d ? d_wdata : '0;
      end
    end
  end

  // Response contents for the edge entering RESP (from IDLE only on a fault).
  always_comb begin
    resp_port = (state == ST_IDLE) ? (grant_d ? PORT_D : PORT_IF) : lat_port;
    resp_err  = (state == ST_IDLE);
    resp_data = (state == ST_ACCESS && !lat_we) ? mem_data_output : '0;
  end

  // Registered per-port responses; everything defaults to zero outside RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_ack   <= 1'b0;
      if_rdata <= '0;
      if_err   <= 1'b0;
      d_ack    <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      if_ack   <= 1'b0;
      if_rdata <= '0;
      if_err   <= 1'b0;
      d_ack    <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
      if (state_nxt == ST_RESP) begin
        if (resp_port == PORT_IF) begin
          if_ack   <= 1'b1;
          if_rdata <= resp_data;
          if_err   <= resp_err;
        end else begin
          d_ack    <= 1'b1;
          d_rdata  <= resp_data;
          d_err    <= resp_err;
        end
      end
    end
  end

  // Memory strobes decode from state only, so reset removes them at once.
  always_comb begin
    mem_rd         = (state == ST_ACCESS) && !lat_we;
    mem_wd         = (state == ST_ACCESS) && lat_we;
    mem_dir        = (state == ST_ACCESS) ? lat_addr : '0;
    mem_data_input = (state == ST_ACCESS) ? lat_wdata : '0;
    busy           = (state != ST_IDLE);
    fsm_state      = state;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized two-port traffic,
// checked every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          DEPTH = 64;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        if_ack, if_err, d_ack, d_err, mem_rd, mem_wd, busy;
  logic [31:0] if_rdata, d_rdata, mem_dir, mem_data_input, mem_data_output;
  state_t      fsm_state;

  mem_arbiter #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_dir(mem_dir), .mem_data_input(mem_data_input), .mem_rd(mem_rd), .mem_wd(mem_wd),
    .mem_data_output(mem_data_output), .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- memory behind the arbiter ----------------
  function automatic logic [31:0] init_word(input int i);
    return (i == 1) ? 32'h0085_3022 : (32'hA5A5_0000 ^ (32'(i) * 32'h0101_0137));
  endfunction

  logic [31:0] mem_array [0:DEPTH-1];
  logic [31:0] mem_off;
  assign mem_off         = mem_dir - BASE;
  assign mem_data_output = mem_array[mem_off[7:2]];

  // Preload, then write on every rising edge with mem_wd high.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_array[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_wd) mem_array[mem_off[7:2]] <= mem_data_input;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int gap_pct = 0;

  txn_t        if_q[$];
  txn_t        d_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [0:DEPTH-1];
  int          obs_port[$];
  int          obs_cyc[$];

  bit          m_active = 0;
  int          m_t = 0;
  bit          m_fault = 0;
  bit          m_port = 0;   // 0 = fetch, 1 = data
  bit          m_last = 0;   // last granted port
  bit          m_we = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(4 * DEPTH)) && (a[1:0] == 2'b00);
  endfunction

  // Advance the model by one clock and compare every observable output.
  task automatic model_check(output bit ack_now, output bit ack_port);
    bit          e_acc, e_ack, e_if, e_d;
    logic [31:0] e_rd;
    if (m_active) m_t++;
    if (m_active && m_t == (m_fault ? 2 : 3)) m_active = 0;
    e_acc = m_active && !m_fault && (m_t == 1);
    e_ack = m_active && (m_t == (m_fault ? 1 : 2));
    e_rd  = '0;
    if (e_ack && exp_q.size() > 0) e_rd = exp_q.pop_front();
    e_if = e_ack && (m_port == 0);
    e_d  = e_ack && (m_port == 1);
    check_eq("busy", busy, m_active);
    check_eq("mem_rd", mem_rd, e_acc && !m_we);
    check_eq("mem_wd", mem_wd, e_acc && m_we);
    if (e_acc) check_eq("mem_dir", mem_dir, m_addr);
    if (e_acc && m_we) check_eq("mem_data_input", mem_data_input, m_wdata);
    check_eq("if_ack", if_ack, e_if);
    check_eq("if_rdata", if_rdata, e_if ? e_rd : 32'h0);
    check_eq("if_err", if_err, e_if && m_fault);
    check_eq("d_ack", d_ack, e_d);
    check_eq("d_rdata", d_rdata, e_d ? e_rd : 32'h0);
    check_eq("d_err", d_err, e_d && m_fault);
    check_eq("ack_both", if_ack && d_ack, 0);
    if (if_ack) begin obs_port.push_back(0); obs_cyc.push_back(cyc); end
    if (d_ack)  begin obs_port.push_back(1); obs_cyc.push_back(cyc); end
    ack_now  = e_ack;
    ack_port = m_port;
  endtask

  // Requesters: drop on ack, present the next queued transaction (maybe after a gap).
  task automatic drive(input bit ack_now, input bit ack_port);
    txn_t t;
    if (ack_now) begin
      if (ack_port) d_req = 1'b0;
      else if_req = 1'b0;
    end
    if (!if_req && if_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      t = if_q.pop_front();
      if_req = 1'b1; if_addr = t.addr;
    end
    if (!d_req && d_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      t = d_q.pop_front();
      d_req = 1'b1; d_addr = t.addr; d_we = t.we; d_wdata = t.wdata;
    end
  endtask

  // If idle with requests pending, pick the winner for the coming edge and predict its result.
  task automatic model_decide();
    int idx;
    if (m_active || rst || !(if_req || d_req)) return;
    m_port  = (d_req && (!if_req || m_last == 0)) ? 1'b1 : 1'b0;
    m_last  = m_port;
    m_addr  = m_port ? d_addr : if_addr;
    m_we    = m_port ? d_we : 1'b0;
    m_wdata = m_port ? d_wdata : 32'h0;
    m_fault = !addr_ok(m_addr);
    m_active = 1; m_t = 0;
    idx = int'((m_addr - BASE) >> 2);
    if (m_fault || m_we) exp_q.push_back(32'h0);
    else exp_q.push_back(ref_mem[idx]);
    if (!m_fault && m_we) ref_mem[idx] = m_wdata;
  endtask

  task automatic step();
    bit a, p;
    @(negedge clk);
    cyc++;
    model_check(a, p);
    drive(a, p);
    model_decide();
  endtask

  // Called at a falling edge; asserts reset mid-cycle, checks the cleared outputs, releases.
  task automatic apply_reset();
    rst = 1'b1;
    m_active = 0; m_last = 0; exp_q.delete();
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_state", fsm_state, ST_IDLE);
    check_eq("rst_mem_rd", mem_rd, 0);
    check_eq("rst_mem_wd", mem_wd, 0);
    check_eq("rst_acks", {if_ack, d_ack}, 0);
    check_eq("rst_errs", {if_err, d_err}, 0);
    check_eq("rst_if_rdata", if_rdata, 0);
    check_eq("rst_d_rdata", d_rdata, 0);
    @(negedge clk);
    cyc++;
    check_eq("rst_hold_acks", {if_ack, d_ack}, 0);
    check_eq("rst_hold_mem_wd", mem_wd, 0);
    rst = 1'b0;
    drive(0, 0);
    model_decide();
  endtask

  task automatic drain(input int max_cycles, input string tag);
    int n = 0;
    while (!(if_q.size() == 0 && d_q.size() == 0 && !if_req && !d_req && !m_active)
           && n < max_cycles) begin
      step();
      n++;
    end
    check_eq({tag, "_done_in_budget"}, n < max_cycles, 1);
  endtask

  task automatic push_if(input logic [31:0] a);
    if_q.push_back('{a, 1'b0, 32'h0});
  endtask

  task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
    d_q.push_back('{a, we, wd});
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE - 32'(4 * $urandom_range(1, 4));
      1:       return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 4));
      2:       return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
      default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    @(negedge clk);
    apply_reset();

    // Single fetch of word 1.
    push_if(32'h0040_0004);
    drain(50, "fetch");

    // Store then load of the same data word.
    push_d(1'b1, 32'h0040_0010, 32'hDEAD_BEEF);
    push_d(1'b0, 32'h0040_0010, 32'h0);
    drain(50, "store_load");
    check_eq("store_in_mem", mem_array[4], 32'hDEAD_BEEF);

    // Out-of-window and misaligned data accesses.
    push_d(1'b1, 32'h003F_FFFC, 32'h1234_5678);
    push_d(1'b0, 32'h0040_0100, 32'h0);
    push_d(1'b0, 32'h0040_0002, 32'h0);
    drain(50, "faults");

    // Both ports held continuously from reset: strict alternation starting with data.
    for (int i = 0; i < 4; i++) begin
      push_if(BASE + 32'(4 * i));
      push_d(1'b0, BASE + 32'(4 * (i + 8)), 32'h0);
    end
    drive(0, 0);
    @(negedge clk);
    cyc++;
    obs_port.delete(); obs_cyc.delete();
    apply_reset();
    drain(100, "round_robin");
    check_eq("rr_acks", obs_port.size(), 8);
    if (obs_port.size() >= 4) begin
      check_eq("rr_grant0", obs_port[0], 1);
      check_eq("rr_grant1", obs_port[1], 0);
      check_eq("rr_grant2", obs_port[2], 1);
      check_eq("rr_grant3", obs_port[3], 0);
      for (int i = 0; i < 3; i++) check_eq("rr_spacing", obs_cyc[i + 1] - obs_cyc[i], 3);
    end

    // Reset while a store is in its memory cycle, then let the held store finish.
    push_d(1'b1, 32'h0040_0020, 32'hCAFE_F00D);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      ok = m_active && !m_fault && m_we && (m_t == 1);
    end
    check_eq("reached_store_access", ok, 1);
    check_eq("store_access_wd", mem_wd, 1);
    obs_port.delete(); obs_cyc.delete();
    apply_reset();
    drain(50, "reset_store");
    check_eq("reset_store_acks", obs_port.size(), 1);
    check_eq("reset_store_mem", mem_array[8], 32'hCAFE_F00D);

    // Randomized mixed traffic with idle gaps.
    gap_pct = 30;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) push_if(rand_addr());
      else push_d(1'($urandom_range(0, 1)), rand_addr(), $urandom);
    end
    drain(5000, "random");
    for (int i = 0; i < DEPTH; i++) check_eq("final_mem", mem_array[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BASE_ADDR, 32'h00400000, byte address of word 0 of the unified memory.
REQ-002 Parameter DEPTH_WORDS, 64, number of 32-bit words in the memory.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch read request, held until if_ack.
REQ-006 if_addr  input  32  fetch byte address, stable while if_req high.
REQ-007 if_ack  output  1  one-cycle completion pulse for fetch port.
REQ-008 if_rdata  output  32  fetched word, valid while if_ack high.
REQ-009 if_err  output  1  fetch address fault, valid while if_ack high.
REQ-010 d_req  input  1  data-port request, held until d_ack.
REQ-011 d_we  input  1  1 = store, 0 = load; stable while d_req high.
REQ-012 d_addr  input  32  data byte address, stable while d_req high.
REQ-013 d_wdata  input  32  store data, stable while d_req high.
REQ-014 d_ack  output  1  one-cycle completion pulse for data port.
REQ-015 d_rdata  output  32  load result, valid while d_ack high.
REQ-016 d_err  output  1  data address fault, valid while d_ack high.
REQ-017 mem_dir  output  32  byte address to memory.
REQ-018 mem_data_input  output  32  write data to memory.
REQ-019 mem_rd  output  1  memory read enable.
REQ-020 mem_wd  output  1  memory write enable.
REQ-021 mem_data_output  input  32  memory read data, combinational from mem_dir.
REQ-022 busy  output  1  high whenever state is not IDLE.

Function
REQ-023 FSM states IDLE, ACCESS, RESP; one transaction in flight at a time.
REQ-024 IDLE: no request -> stay; any request -> grant one port, latch its addr/we/wdata, go ACCESS (valid address) or RESP with fault (invalid address).
REQ-025 Single requester always wins; both requesting -> grant the port not granted last (round-robin via last_grant register, updated on every grant).
REQ-026 Fetch is always a read; fetch never drives mem_wd.
REQ-027 Valid address: BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS and addr[1:0] == 0; otherwise fault.
REQ-028 ACCESS lasts exactly one cycle: mem_dir = latched addr; mem_rd = !we; mem_wd = we; mem_data_input = latched wdata; load data captured from mem_data_output at the ACCESS->RESP edge.
REQ-029 mem_rd and mem_wd SHALL be 0 in IDLE and RESP, never both 1, and never asserted for a faulted request.
REQ-030 RESP lasts one cycle: granted port's ack = 1; rdata = captured word for loads/fetches, 0 for stores and faults; err = fault flag; then IDLE.
REQ-031 Latency: request present in IDLE at edge k -> ack high in cycle k+2; sustained throughput one transaction per 3 cycles.
REQ-032 Non-granted port's ack, rdata, err SHALL be 0; ack never asserted to both ports in one cycle.
REQ-033 Request changes while not IDLE are ignored; a request still held after its ack is treated as a new request in the following IDLE.
REQ-034 All outputs registered except mem_* which decode from state and latched registers only.

Reset
REQ-035 reset asserts state = IDLE, last_grant = fetch (first tie goes to data), all latched registers and all outputs = 0, asynchronously.
REQ-036 Reset during ACCESS drops mem_wd/mem_rd immediately; no ack issued; still-held requests re-arbitrate after release.

Structure
REQ-037 Package mem_arb_pkg holds state encoding, port-id constants (PORT_IF, PORT_D), default BASE_ADDR and DEPTH_WORDS.
REQ-038 One combinational sub-module mem_addr_check (addr, BASE_ADDR, DEPTH_WORDS -> fault) instantiated once on the selected address.

Verification
REQ-039 Fetch only, if_addr=32'h00400004, memory word1=32'h00853022 -> if_ack 2 cycles later, if_rdata=32'h00853022, if_err=0, mem_wd never high.
REQ-040 Store d_addr=32'h00400010, d_wdata=32'hDEADBEEF, then load same address -> mem_wd one cycle with mem_dir=32'h00400010; load returns 32'hDEADBEEF.
REQ-041 if_req and d_req both held continuously from reset -> grants alternate D, IF, D, IF; acks every 3 cycles, never simultaneous.
REQ-042 d_addr=32'h003FFFFC, then 32'h00400100, then 32'h00400002 -> each d_ack with d_err=1, d_rdata=0, mem_rd/mem_wd never asserted.
REQ-043 Assert reset during ACCESS of a store -> mem_wd falls in same cycle, no d_ack; after release held store completes once with d_ack.
